// File: rtl/alu_pkg.sv
// Shared opcodes and arbiter state for the ALU arbiter slice.
// Config macro ALU_ARB_ROUND_ROBIN_EN is consumed by alu_arb_picker/alu_arbiter.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_EQ  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1001;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1110;

  typedef enum logic {
    IDLE,
    RESP
  } arb_state_t;

endpackage

// File: rtl/Alu.sv
// Existing 32-bit combinational ALU shared by the arbiter.
// Unlisted opcodes return zero.
module Alu
  import alu_pkg::*;
(
  input  logic [3:0]  ALU_OP_i,
  input  logic [31:0] ALU_RS1_i,
  input  logic [31:0] ALU_RS2_i,
  output logic [31:0] ALU_RD_o,
  output logic        ALU_ZR_o
);

  logic [4:0] shamt;

  assign shamt = ALU_RS2_i[4:0];

  always_comb begin
    ALU_RD_o = '0;
    case (ALU_OP_i)
      ALU_AND: ALU_RD_o = ALU_RS1_i & ALU_RS2_i;
      ALU_OR:  ALU_RD_o = ALU_RS1_i | ALU_RS2_i;
      ALU_ADD: ALU_RD_o = ALU_RS1_i + ALU_RS2_i;
      ALU_EQ:  ALU_RD_o = {31'b0, ALU_RS1_i == ALU_RS2_i};
      ALU_SLL: ALU_RD_o = ALU_RS1_i << shamt;
      ALU_SRL: ALU_RD_o = ALU_RS1_i >> shamt;
      ALU_SRA: ALU_RD_o = $signed(ALU_RS1_i) >>> shamt;
      ALU_XOR: ALU_RD_o = ALU_RS1_i ^ ALU_RS2_i;
      ALU_NOR: ALU_RD_o = ~(ALU_RS1_i | ALU_RS2_i);
      ALU_SUB: ALU_RD_o = ALU_RS1_i - ALU_RS2_i;
      ALU_SLT: ALU_RD_o = {31'b0,
                 $signed(ALU_RS1_i) < $signed(ALU_RS2_i)};
      default: ALU_RD_o = '0;
    endcase
  end

  assign ALU_ZR_o = (ALU_RD_o == '0);

endmodule

// File: rtl/alu_arb_picker.sv
// Grant picker: round-robin from ptr when ALU_ARB_ROUND_ROBIN_EN
// is defined, otherwise fixed priority (lowest index wins).
module alu_arb_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic               en,
`ifdef ALU_ARB_ROUND_ROBIN_EN
  input  logic [IDXW-1:0]    ptr,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDXW-1:0]    idx
);

  logic hit;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [IDXW-1:0] j;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IDXW'((int'(ptr) + k) % NUM_REQ);
      if (!hit && valid[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
  end
`else
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid[k]) begin
        hit = 1'b1;
        idx = IDXW'(k);
      end
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (en && hit) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one Alu between NUM_REQ valid/ready requesters, one op in flight.
// ALU_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module alu_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            REQ_VALID_i,
  output logic [NUM_REQ-1:0]            REQ_READY_o,
  input  logic [NUM_REQ*4-1:0]          REQ_OP_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_RS1_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_RS2_i,
  output logic [NUM_REQ-1:0]            RSP_VALID_o,
  input  logic [NUM_REQ-1:0]            RSP_READY_i,
  output logic [DATA_WIDTH-1:0]         RSP_RD_o,
  output logic                          RSP_ZR_o
);
  import alu_pkg::*;

  localparam int IDXW = $clog2(NUM_REQ);

  if (DATA_WIDTH != 32) begin : g_width_chk
    $error("alu_arbiter: DATA_WIDTH must be 32");
  end
  if (NUM_REQ < 2) begin : g_req_chk
    $error("alu_arbiter: NUM_REQ must be at least 2");
  end

  arb_state_t              state_q, state_d;
  logic [IDXW-1:0]         owner_q;
  logic [IDXW-1:0]         idx;
  logic [NUM_REQ-1:0]      gnt;
  logic                    rsp_hs, free, fire;
  logic [3:0]              sel_op;
  logic [DATA_WIDTH-1:0]   sel_rs1, sel_rs2;
  logic [DATA_WIDTH-1:0]   alu_rd;
  logic                    alu_zr;

  // Releasing the held result frees the ALU in the same cycle.
  assign rsp_hs = (state_q == RESP) & RSP_READY_i[owner_q];
  assign free   = ~rst & ((state_q == IDLE) | rsp_hs);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [IDXW-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (fire) begin
      ptr_q <= (idx == IDXW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end
`endif

  alu_arb_picker #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_picker (
    .valid (REQ_VALID_i),
    .en    (free),
`ifdef ALU_ARB_ROUND_ROBIN_EN
    .ptr   (ptr_q),
`endif
    .gnt   (gnt),
    .idx   (idx)
  );

  assign REQ_READY_o = gnt;
  assign fire        = |(REQ_VALID_i & gnt);

  assign sel_op  = REQ_OP_i[4*int'(idx) +: 4];
  assign sel_rs1 = REQ_RS1_i[DATA_WIDTH*int'(idx) +: DATA_WIDTH];
  assign sel_rs2 = REQ_RS2_i[DATA_WIDTH*int'(idx) +: DATA_WIDTH];

  Alu u_alu (
    .ALU_OP_i  (sel_op),
    .ALU_RS1_i (sel_rs1),
    .ALU_RS2_i (sel_rs2),
    .ALU_RD_o  (alu_rd),
    .ALU_ZR_o  (alu_zr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (fire) state_d = RESP;
      RESP: if (!fire && rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      RSP_RD_o <= '0;
      RSP_ZR_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        owner_q  <= idx;
        RSP_RD_o <= alu_rd;
        RSP_ZR_o <= alu_zr;
      end
    end
  end

  always_comb begin
    RSP_VALID_o = '0;
    if (state_q == RESP) RSP_VALID_o[owner_q] = 1'b1;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed cases then random traffic.
// Expected grants follow ALU_ARB_ROUND_ROBIN_EN when it is defined.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N  = 2;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    REQ_VALID_i;
  logic [N-1:0]    REQ_READY_o;
  logic [N*4-1:0]  REQ_OP_i;
  logic [N*DW-1:0] REQ_RS1_i;
  logic [N*DW-1:0] REQ_RS2_i;
  logic [N-1:0]    RSP_VALID_o;
  logic [N-1:0]    RSP_READY_i;
  logic [DW-1:0]   RSP_RD_o;
  logic            RSP_ZR_o;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .REQ_VALID_i (REQ_VALID_i),
    .REQ_READY_o (REQ_READY_o),
    .REQ_OP_i    (REQ_OP_i),
    .REQ_RS1_i   (REQ_RS1_i),
    .REQ_RS2_i   (REQ_RS2_i),
    .RSP_VALID_o (RSP_VALID_o),
    .RSP_READY_i (RSP_READY_i),
    .RSP_RD_o    (RSP_RD_o),
    .RSP_ZR_o    (RSP_ZR_o)
  );

  typedef struct {
    int          dst;
    logic [31:0] rd;
    logic        zr;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [N-1:0] pend;
  logic [N-1:0] rsp_rdy;
  logic [3:0]   op_a[N];
  logic [31:0]  a_a[N];
  logic [31:0]  b_a[N];
  logic [N-1:0] last_gnt;
  bit           m_busy;
  int           m_owner;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  int           m_ptr;
`endif

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the opcode table.
  function automatic logic [32:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic [31:0] ones;
    int          sh;
    ones = '1;
    sh   = int'(b[4:0]);
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = (a == b) ? 32'd1 : 32'd0;
      4'b0100: r = a << sh;
      4'b0101: r = a >> sh;
      4'b0111: r = (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
      4'b1000: r = a ^ b;
      4'b1001: r = ~(a | b);
      4'b1010: r = a - b;
      4'b1110: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {r == 32'd0, r};
  endfunction

  function automatic int pick(input logic [N-1:0] v);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
    for (int k = 0; k < N; k++)
      if (v[k]) return k;
`endif
    return -1;
  endfunction

  task automatic issue(input int i, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    pend[i] = 1'b1;
    op_a[i] = op;
    a_a[i]  = a;
    b_a[i]  = b;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      REQ_VALID_i[i]          = pend[i];
      REQ_OP_i[4*i +: 4]      = op_a[i];
      REQ_RS1_i[DW*i +: DW]   = a_a[i];
      REQ_RS2_i[DW*i +: DW]   = b_a[i];
    end
    RSP_READY_i = rsp_rdy;
  endtask

  task automatic eval();
    logic [N-1:0] one;
    logic [N-1:0] er;
    logic [32:0]  r;
    bit           mfree;
    int           w;
    exp_t         e;
    one   = 1;
    mfree = !m_busy || RSP_READY_i[m_owner];
    w     = mfree ? pick(REQ_VALID_i) : -1;
    er    = (w >= 0) ? one << w : '0;
    chk("req_ready", 32'(REQ_READY_o), 32'(er));
    chk("rsp_valid", 32'(RSP_VALID_o), m_busy ? 32'(one << m_owner) : 32'd0);
    last_gnt = REQ_READY_o & REQ_VALID_i;
    if (w >= 0) begin
      r     = alu_ref(op_a[w], a_a[w], b_a[w]);
      e.dst = w;
      e.rd  = r[31:0];
      e.zr  = r[32];
      exp_q.push_back(e);
      pend[w] = 1'b0;
      m_busy  = 1'b1;
      m_owner = w;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      m_ptr   = (w + 1) % N;
`endif
    end else if (m_busy && RSP_READY_i[m_owner]) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive();
    @(negedge clk); #1;
    eval();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst  = 1'b1;
    pend = '0;
    drive();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_busy  = 1'b0;
    m_owner = 0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    m_ptr   = 0;
`endif
    chk("reset_rsp_valid", 32'(RSP_VALID_o), 32'd0);
    chk("reset_req_ready", 32'(REQ_READY_o), 32'd0);
    chk("reset_rd", RSP_RD_o, 32'd0);
    chk("reset_zr", 32'(RSP_ZR_o), 32'd0);
  endtask

  // Monitor: every presented result must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && RSP_VALID_o != '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got valid %b with empty scoreboard",
                 RSP_VALID_o);
      end else begin
        mon_e = exp_q[0];
        chk("mon_dst", 32'(RSP_VALID_o), 32'(1) << mon_e.dst);
        chk("mon_rd", RSP_RD_o, mon_e.rd);
        chk("mon_zr", 32'(RSP_ZR_o), 32'(mon_e.zr));
        if (|(RSP_VALID_o & RSP_READY_i)) void'(exp_q.pop_front());
      end
    end
  end

  int          exp_g[4];
  logic [3:0]  sweep_ops[8];
  logic [31:0] sweep_a[3];
  logic [31:0] sweep_b[3];

  initial begin
    pend    = '0;
    rsp_rdy = '1;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      a_a[i]  = '0;
      b_a[i]  = '0;
    end
    drive();
    do_reset();

    // Single ADD, then zero flag and SRA on req1.
    issue(0, ALU_ADD, 32'd15, 32'd10);
    step(); step();
    chk("add_valid", 32'(RSP_VALID_o), 32'd1);
    chk("add_rd", RSP_RD_o, 32'd25);
    chk("add_zr", 32'(RSP_ZR_o), 32'd0);
    step();
    chk("add_valid_drop", 32'(RSP_VALID_o), 32'd0);

    issue(1, ALU_ADD, 32'd10, 32'hFFFF_FFF6);
    step(); step();
    chk("zr_valid", 32'(RSP_VALID_o), 32'd2);
    chk("zr_rd", RSP_RD_o, 32'd0);
    chk("zr_flag", 32'(RSP_ZR_o), 32'd1);
    issue(1, ALU_SRA, 32'h8000_0000, 32'd4);
    step(); step();
    chk("sra_rd", RSP_RD_o, 32'hF800_0000);
    step();

    // Contention straight after reset.
    do_reset();
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      issue(0, ALU_ADD, 32'(k), 32'd1);
      issue(1, ALU_ADD, 32'(k), 32'd2);
      step();
      chk("contention_gnt", 32'(last_gnt), 32'(1) << exp_g[k]);
    end
    pend = '0;
    step(); step();

    // Backpressure on req0 with req1 waiting.
    rsp_rdy = 2'b10;
    issue(0, ALU_SUB, 32'd15, 32'd10);
    step();
    issue(1, ALU_XOR, 32'hF0F0_0000, 32'h0FF0_00FF);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_rd_hold", RSP_RD_o, 32'd5);
      chk("bp_ready_low", 32'(REQ_READY_o), 32'd0);
    end
    rsp_rdy = 2'b11;
    step();
    chk("bp_release_gnt", 32'(REQ_READY_o), 32'd2);
    step();
    chk("bp_xor_valid", 32'(RSP_VALID_o), 32'd2);
    chk("bp_xor_rd", RSP_RD_o, 32'hFF00_00FF);
    step();

    // Reset while a result is held.
    rsp_rdy = 2'b00;
    issue(0, ALU_ADD, 32'd1, 32'd2);
    step(); step();
    chk("pre_reset_valid", 32'(RSP_VALID_o), 32'd1);
    do_reset();
    rsp_rdy = 2'b11;
    issue(0, ALU_OR, 32'd3, 32'd4);
    issue(1, ALU_OR, 32'd5, 32'd6);
    step();
    chk("post_reset_gnt", 32'(last_gnt), 32'd1);
    pend = '0;
    step(); step();

    // Opcode sweep, back-to-back on req0.
    sweep_ops = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
                  ALU_SLL, ALU_SRL, ALU_SLT, ALU_EQ};
    sweep_a   = '{32'hA5A5_A5A5, 32'd7, 32'hFFFF_FFFE};
    sweep_b   = '{32'h5A5A_5A5A, 32'd3, 32'd5};
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++) begin
        issue(0, sweep_ops[k], sweep_a[p], sweep_b[p]);
        step();
        chk("sweep_issue", 32'(last_gnt), 32'd1);
      end
    end
    pend = '0;
    step(); step();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1)
          issue(i, 4'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40))
                                            : $urandom);
        else if (pend[i] && $urandom_range(0, 7) == 0)
          pend[i] = 1'b0;
        rsp_rdy[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    pend    = '0;
    rsp_rdy = '1;
    step(); step(); step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `Alu` instance between `NUM_REQ` requesters, such as the execute stage and a multi-cycle helper unit, using valid/ready handshakes. Each accepted operation gets a registered result one cycle later. Only one operation is in flight at a time. With all consumers ready, the block sustains one operation per cycle. The arbiter sits between the requesters and the combinational ALU, and it owns grant selection, operand muxing and result buffering.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters (≥2).
- `DATA_WIDTH`, 32, operand/result width. The `Alu` is fixed at 32, so any other value is illegal.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `REQ_VALID_i`  in  NUM_REQ  per-requester operation valid.
- `REQ_READY_o`  out  NUM_REQ  per-requester accept (at most one bit high).
- `REQ_OP_i`  in  NUM_REQ*4  packed 4-bit ALU opcodes; requester i uses bits [4i+3:4i].
- `REQ_RS1_i`  in  NUM_REQ*DATA_WIDTH  packed operand 1.
- `REQ_RS2_i`  in  NUM_REQ*DATA_WIDTH  packed operand 2.
- `RSP_VALID_o`  out  NUM_REQ  one-hot result valid, addressed to the originating requester.
- `RSP_READY_i`  in  NUM_REQ  per-requester result accept.
- `RSP_RD_o`  out  DATA_WIDTH  registered ALU result.
- `RSP_ZR_o`  out  1  registered ALU zero flag.

## Operation
- States: `IDLE` (no held result) and `RESP` (result held, waiting for the consumer).
- Issue-free condition: `free = (state==IDLE) | (RSP_VALID_o[g] & RSP_READY_i[g])`, where g is the held owner.
- When `free` is true, the picker selects one valid requester s. `REQ_READY_o[s]=1`, and every other bit is 0.
- When `free` is false, `REQ_READY_o` is 0.
- The selected operands and opcode drive the `Alu` combinationally.
- On fire (`REQ_VALID_i[s] & REQ_READY_o[s]`):
  - `ALU_RD_o` is registered into `RSP_RD_o`, and `ALU_ZR_o` into `RSP_ZR_o`.
  - The owner register is set to s, and the state goes to `RESP`.
- In `RESP` with a response handshake and no new fire, the state goes to `IDLE` and `RSP_VALID_o` goes to 0.
- With a handshake and a fire in the same cycle, the state stays `RESP` and the new result/owner loads.
- While `RESP` waits, `RSP_RD_o`, `RSP_ZR_o` and the owner are stable.
- Opcodes are not checked. Any 4-bit value passes through, and the result is whatever `Alu` returns.
- Reset, including mid-operation: state `IDLE`, `RSP_VALID_o=0`, `REQ_READY_o=0` (it depends only on state and valid inputs after reset), `RSP_RD_o=0`, `RSP_ZR_o=0`, owner 0, round-robin pointer 0. An in-flight result is discarded with no handshake.
- A requester that drops `REQ_VALID_i` before being granted loses nothing.

## Timing
- Latency: fire in cycle N gives `RSP_VALID_o` high in cycle N+1.
- Throughput: 1 op/cycle while the current owner's `RSP_READY_i` is held high.
- `REQ_READY_o` is combinational from `REQ_VALID_i`, `RSP_READY_i` and state. `RSP_*` outputs are registers only.
- The ALU path is a single cycle from the operand mux to the result register.

## Configuration
- `ALU_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration. The search starts at pointer p; on fire, p becomes (s+1) mod NUM_REQ.
  - p updates only on fire.
- Undefined: fixed priority, where the lowest valid index wins, there is no pointer register, and starvation is permitted.

## Structure
- `alu_pkg` holds:
  - opcode localparams: `ALU_AND=0000`, `ALU_OR=0001`, `ALU_ADD=0010`, `ALU_EQ=0011`, `ALU_SLL=0100`, `ALU_SRL=0101`, `ALU_SRA=0111`, `ALU_XOR=1000`, `ALU_NOR=1001`, `ALU_SUB=1010`, `ALU_SLT=1110`.
  - the `arb_state_t` enum {IDLE, RESP}.
- Sub-module `alu_arb_picker`: combinational one-hot/index select from valid, enable and pointer. The macro is confined here plus the pointer register.
- The existing `Alu` is instantiated unchanged.

## Test plan
- Single ADD on req0, 15+10, `RSP_READY_i` high: `RSP_VALID_o=01` one cycle after fire, `RSP_RD_o=25`, `RSP_ZR_o=0`, then `RSP_VALID_o=00`.
- Zero flag: req1 ADD 10 + 0xFFFFFFF6 gives `RSP_VALID_o=10`, `RSP_RD_o=0`, `RSP_ZR_o=1`. Next, SRA 0x80000000 by 4 gives `0xF8000000`.
- Contention, both requesters valid for 4 cycles, consumers always ready:
  - with `ALU_ARB_ROUND_ROBIN_EN`, grants are 0,1,0,1;
  - without it, grants are 0,0,0,0, and req1 is never ready.
- Backpressure: req0 SUB 15-10, `RSP_READY_i[0]=0` for 3 cycles. `RSP_RD_o` stays 5 and stable, and `REQ_READY_o=00` throughout. On release, the same-cycle grant of a pending req1 XOR yields back-to-back results.
- Reset mid-operation: assert `rst` while `RSP_VALID_o=01`. The next cycle has all outputs 0. After release, the first contention grant goes to req0.
- Opcode sweep on req0 (AND/OR/XOR/NOR/SLL/SRL/SLT/EQ, operands 0xA5A5A5A5/0x5A5A5A5A and small values): each `RSP_RD_o` equals the standalone `Alu` result for the same inputs.
